// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares the single RAM port between the CPU (fetch/load/store path) and the
// IO/display requester. The CPU normally has priority, but after CPU_BURST
// consecutive CPU wins while IO was waiting, IO takes the next slot.
// Every access takes two cycles: an ISSUE cycle that drives the RAM address,
// write data and write enable, then a RESP cycle that returns the RAM read data.
// In RESP the arbiter selects the next access, so back-to-back accesses run at
// one every two cycles.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-high; clears state and all outputs at once
//   cpu_req      CPU access request, held until cpu_gnt
//   cpu_we       CPU write enable, stable while cpu_req
//   cpu_addr     CPU address, stable while cpu_req
//   cpu_wdata    CPU write data, stable while cpu_req
//   io_req       IO access request, held until io_gnt
//   io_we        IO write enable
//   io_addr      IO address
//   io_wdata     IO write data
//   mem_rdata    RAM read data, valid the cycle after the address is presented
//   cpu_gnt      one-cycle grant pulse to the CPU (ISSUE cycle)
//   io_gnt       one-cycle grant pulse to IO (ISSUE cycle)
//   cpu_rvalid   one-cycle completion pulse to the CPU (RESP cycle)
//   io_rvalid    one-cycle completion pulse to IO (RESP cycle)
//   rdata        shared read data, non-zero only alongside an rvalid
//   mem_addr     RAM address, zero outside ISSUE
//   mem_wdata    RAM write data, zero outside ISSUE
//   mem_we       RAM write enable, only ever high in ISSUE
//   busy         high whenever an access is in ISSUE or RESP

module mem_arbiter #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16,
  parameter int CPU_BURST = 4,
  parameter int RUN_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [WIDTH-1:0]     cpu_wdata,
  input  logic                 io_req,
  input  logic                 io_we,
  input  logic [ADDR_BITS-1:0] io_addr,
  input  logic [WIDTH-1:0]     io_wdata,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 cpu_gnt,
  output logic                 io_gnt,
  output logic                 cpu_rvalid,
  output logic                 io_rvalid,
  output logic [WIDTH-1:0]     rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_we,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [RUN_BITS-1:0] BURST_MAX = RUN_BITS'(CPU_BURST);

  state_t              state;
  logic                owner;     // 0 = CPU, 1 = IO
  logic [RUN_BITS-1:0] cpu_run;   // CPU wins in a row while IO was waiting

  logic                sel_any;
  logic                sel_io;
  logic [RUN_BITS-1:0] run_next;

  // Selection used whenever a new access may start (IDLE or RESP).
  // IO wins when it is the only requester, or when the CPU has already used
  // its full burst while IO waited. The run counter only grows while IO is
  // actually being held off; any IO win or absent IO request clears it.
  always_comb begin
    sel_any  = cpu_req | io_req;
    sel_io   = io_req & (~cpu_req | (cpu_run == BURST_MAX));
    run_next = '0;
    if (sel_any && !sel_io && io_req) begin
      if (cpu_run >= BURST_MAX) begin
        run_next = BURST_MAX;
      end else begin
        run_next = cpu_run + RUN_BITS'(1);
      end
    end
  end

  // Access sequencer. Grant, completion and busy flags are registered along
  // with the state, so they all clear asynchronously with reset and never
  // glitch on requester inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cpu_run    <= '0;
      cpu_gnt    <= 1'b0;
      io_gnt     <= 1'b0;
      cpu_rvalid <= 1'b0;
      io_rvalid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          cpu_rvalid <= 1'b0;
          io_rvalid  <= 1'b0;
          cpu_run    <= run_next;
          if (sel_any) begin
            state   <= ISSUE;
            owner   <= sel_io;
            cpu_gnt <= ~sel_io;
            io_gnt  <= sel_io;
            busy    <= 1'b1;
          end else begin
            state   <= IDLE;
            cpu_gnt <= 1'b0;
            io_gnt  <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ISSUE: begin
          state      <= RESP;
          cpu_gnt    <= 1'b0;
          io_gnt     <= 1'b0;
          cpu_rvalid <= ~owner;
          io_rvalid  <= owner;
          busy       <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          cpu_gnt    <= 1'b0;
          io_gnt     <= 1'b0;
          cpu_rvalid <= 1'b0;
          io_rvalid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // RAM port is driven straight from the owner's request lines during ISSUE;
  // the grant flags double as the ISSUE/owner decode, so a reset that lands
  // mid-ISSUE drops mem_we immediately and aborts the write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (io_gnt) begin
      mem_addr  = io_addr;
      mem_wdata = io_wdata;
      mem_we    = io_we;
    end
  end

  // Read data is only passed through in RESP so the shared bus stays quiet
  // otherwise.
  always_comb begin
    rdata = '0;
    if (cpu_rvalid || io_rvalid) begin
      rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Directed and randomized bench for mem_arbiter. A small RAM model sits on the
// memory port. The reference model works at the transaction level: an access
// owns the RAM for the two cycles after it is granted, a new access may only
// start on an edge that is not in the middle of one, reads return the last
// value written to that address, and IO is let in after CPU_BURST CPU wins in
// a row while it waited.

module tb_mem_arbiter;

  localparam int WIDTH     = 16;
  localparam int ADDR_BITS = 16;
  localparam int CPU_BURST = 4;
  localparam int RUN_BITS  = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 cpu_req = 1'b0;
  logic                 cpu_we = 1'b0;
  logic [ADDR_BITS-1:0] cpu_addr = '0;
  logic [WIDTH-1:0]     cpu_wdata = '0;
  logic                 io_req = 1'b0;
  logic                 io_we = 1'b0;
  logic [ADDR_BITS-1:0] io_addr = '0;
  logic [WIDTH-1:0]     io_wdata = '0;
  logic [WIDTH-1:0]     mem_rdata;
  logic                 cpu_gnt;
  logic                 io_gnt;
  logic                 cpu_rvalid;
  logic                 io_rvalid;
  logic [WIDTH-1:0]     rdata;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 mem_we;
  logic                 busy;

  mem_arbiter #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .CPU_BURST(CPU_BURST), .RUN_BITS(RUN_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .mem_rdata(mem_rdata),
    .cpu_gnt(cpu_gnt), .io_gnt(io_gnt), .cpu_rvalid(cpu_rvalid), .io_rvalid(io_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM on the arbiter's memory port.
  logic [WIDTH-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // Reference model state
  int               g_cycle = -10;
  bit               g_owner = 1'b0;
  logic [15:0]      g_addr = '0;
  logic [15:0]      g_wdata = '0;
  bit               g_we = 1'b0;
  logic [15:0]      g_rval = '0;
  int               streak = 0;
  logic [15:0]      ref_mem [logic [15:0]];

  // Requester behaviour
  bit cpu_pend = 1'b0;
  bit io_pend = 1'b0;
  int cpu_rate = 0;
  int io_rate = 0;

  // Observed DUT activity for directed checks
  int          gnt_log [$];
  int          gnt_cyc [$];
  logic [15:0] last_io_rdata = '0;
  logic [15:0] last_cpu_rdata = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic checkCycle();
    bit iss;
    bit rsp;
    logic [15:0] exp_rdata;
    iss = (g_cycle == cycle);
    rsp = (g_cycle == cycle - 1);
    exp_rdata = rsp ? (g_we ? mem_rdata : g_rval) : 16'h0000;
    checkOutput("cpu_gnt",    32'(cpu_gnt),    32'(iss && !g_owner));
    checkOutput("io_gnt",     32'(io_gnt),     32'(iss && g_owner));
    checkOutput("mem_addr",   32'(mem_addr),   32'(iss ? g_addr : 16'h0000));
    checkOutput("mem_wdata",  32'(mem_wdata),  32'(iss ? g_wdata : 16'h0000));
    checkOutput("mem_we",     32'(mem_we),     32'(iss && g_we));
    checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(rsp && !g_owner));
    checkOutput("io_rvalid",  32'(io_rvalid),  32'(rsp && g_owner));
    checkOutput("rdata",      32'(rdata),      32'(exp_rdata));
    checkOutput("busy",       32'(busy),       32'(iss || rsp));
  endtask

  task automatic issueCpu(input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    cpu_pend = 1'b1; cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic issueIo(input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    io_pend = 1'b1; io_req = 1'b1; io_we = we; io_addr = addr; io_wdata = wdata;
  endtask

  // One clock: advance the model on the edge, check outputs, then let the
  // requesters react (they may only change after the cycle following a grant).
  task automatic applyStimulus();
    bit pick_io;
    @(posedge clk);
    cycle++;
    if (g_cycle == cycle - 1 && g_we) ref_mem[g_addr] = g_wdata;
    if (g_cycle != cycle - 1) begin
      if (cpu_req || io_req) begin
        pick_io = io_req && (!cpu_req || streak == CPU_BURST);
        g_cycle = cycle;
        g_owner = pick_io;
        g_addr  = pick_io ? io_addr : cpu_addr;
        g_wdata = pick_io ? io_wdata : cpu_wdata;
        g_we    = pick_io ? io_we : cpu_we;
        g_rval  = ref_mem.exists(g_addr) ? ref_mem[g_addr] : 16'hxxxx;
        streak  = (!pick_io && io_req) ? streak + 1 : 0;
      end else begin
        streak = 0;
      end
    end
    #1;
    checkCycle();
    if (cpu_gnt) begin gnt_log.push_back(0); gnt_cyc.push_back(cycle); end
    if (io_gnt)  begin gnt_log.push_back(1); gnt_cyc.push_back(cycle); end
    if (cpu_rvalid) last_cpu_rdata = rdata;
    if (io_rvalid)  last_io_rdata = rdata;
    if (g_cycle == cycle - 1) begin
      if (g_owner) io_pend = 1'b0;
      else cpu_pend = 1'b0;
    end
    if (!cpu_pend) begin
      if (int'($urandom_range(99)) < cpu_rate)
        issueCpu(1'($urandom_range(1)), 16'($urandom_range(31)), 16'($urandom));
      else
        cpu_req = 1'b0;
    end
    if (!io_pend) begin
      if (int'($urandom_range(99)) < io_rate)
        issueIo(1'($urandom_range(1)), 16'($urandom_range(31)), 16'($urandom));
      else
        io_req = 1'b0;
    end
  endtask

  task automatic idleCycles(input int n);
    cpu_rate = 0;
    io_rate = 0;
    repeat (n) applyStimulus();
  endtask

  task automatic resetDut();
    reset = 1'b1;
    cpu_req = 1'b0; io_req = 1'b0; cpu_pend = 1'b0; io_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
    checkOutput("rst_io_gnt",     32'(io_gnt),     32'd0);
    checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("rst_io_rvalid",  32'(io_rvalid),  32'd0);
    checkOutput("rst_mem_we",     32'(mem_we),     32'd0);
    checkOutput("rst_mem_addr",   32'(mem_addr),   32'd0);
    checkOutput("rst_rdata",      32'(rdata),      32'd0);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    g_cycle = -10;
    streak = 0;
  endtask

  function automatic logic [15:0] preloadValue(input int a);
    return 16'(a * 257) ^ 16'h5A5A;
  endfunction

  initial begin
    int k;
    logic [15:0] v5;
    $display("[TB] starting mem_arbiter bench");
    resetDut();

    // Fill the low 32 words so later reads are well defined.
    for (int a = 0; a < 32; a++) begin
      issueCpu(1'b1, 16'(a), preloadValue(a));
      repeat (2) applyStimulus();
    end
    idleCycles(2);

    // Single CPU read of 0x0010 holding 0xBEEF.
    issueCpu(1'b1, 16'h0010, 16'hBEEF);
    idleCycles(3);
    issueCpu(1'b0, 16'h0010, 16'h0000);
    applyStimulus();
    checkOutput("rd_gnt",   32'(cpu_gnt),  32'd1);
    checkOutput("rd_addr",  32'(mem_addr), 32'h0010);
    checkOutput("rd_we",    32'(mem_we),   32'd0);
    applyStimulus();
    checkOutput("rd_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("rd_data",   32'(rdata),      32'hBEEF);
    applyStimulus();
    checkOutput("rd_busy_after", 32'(busy), 32'd0);
    idleCycles(2);

    // CPU write then IO read of the same word, raised on the same edge.
    issueCpu(1'b1, 16'h0020, 16'h1234);
    issueIo(1'b0, 16'h0020, 16'h0000);
    applyStimulus();
    checkOutput("wr_cpu_first", 32'(cpu_gnt), 32'd1);
    checkOutput("wr_we_issue",  32'(mem_we),  32'd1);
    applyStimulus();
    checkOutput("wr_we_resp",   32'(mem_we),  32'd0);
    applyStimulus();
    checkOutput("io_gnt_next",  32'(io_gnt),  32'd1);
    checkOutput("io_addr",      32'(mem_addr), 32'h0020);
    applyStimulus();
    checkOutput("io_rdata", 32'(last_io_rdata), 32'h1234);
    idleCycles(3);

    // Both requesters held high: CPU_BURST CPU grants, then one IO grant.
    gnt_log.delete();
    issueCpu(1'b0, 16'h0003, 16'h0000);
    issueIo(1'b0, 16'h0004, 16'h0000);
    cpu_rate = 100;
    io_rate = 100;
    repeat (24) applyStimulus();
    checkOutput("burst_count_ok", 32'(gnt_log.size() >= 10), 32'd1);
    if (gnt_log.size() >= 10) begin
      for (int i = 0; i < 10; i++)
        checkOutput($sformatf("burst_owner%0d", i), 32'(gnt_log[i]), 32'((i % 5) == 4));
    end
    idleCycles(6);

    // IO alone, three back-to-back accesses.
    gnt_log.delete();
    gnt_cyc.delete();
    k = cycle;
    issueIo(1'b0, 16'h0007, 16'h0000);
    io_rate = 100;
    repeat (6) applyStimulus();
    checkOutput("io_only_count_ok", 32'(gnt_cyc.size() >= 3), 32'd1);
    if (gnt_cyc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("io_only_cyc%0d", i), 32'(gnt_cyc[i]), 32'(k + 1 + 2 * i));
        checkOutput($sformatf("io_only_own%0d", i), 32'(gnt_log[i]), 32'd1);
      end
    end
    idleCycles(6);

    // Reset in the middle of a CPU write ISSUE cycle.
    issueCpu(1'b1, 16'h0005, 16'hDEAD);
    applyStimulus();
    checkOutput("pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_mem_we",  32'(mem_we),  32'd0);
    checkOutput("async_cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("async_busy",    32'(busy),    32'd0);
    resetDut();
    v5 = preloadValue(5);
    issueCpu(1'b0, 16'h0005, 16'h0000);
    repeat (2) applyStimulus();
    checkOutput("post_rst_rdata", 32'(last_cpu_rdata), 32'(v5));
    idleCycles(3);

    // Randomized traffic at several mixes.
    cpu_rate = 50; io_rate = 50;
    repeat (300) applyStimulus();
    idleCycles(6);
    cpu_rate = 90; io_rate = 40;
    repeat (300) applyStimulus();
    idleCycles(6);
    cpu_rate = 20; io_rate = 90;
    repeat (300) applyStimulus();
    idleCycles(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
